// File: rtl/spi_result_tx.sv
// SPI master transmitter returning result entries to the host as 72-bit
// MSB-first frames [VALUE][ROW][COL][FLAGS], fed from a small result FIFO.
module spi_result_tx #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IDX_W      = 16,
  parameter int unsigned CLK_DIV    = 10,
  parameter int unsigned CS_GAP     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_val,
  input  logic [IDX_W-1:0]  res_row,
  input  logic [IDX_W-1:0]  res_col,
  input  logic              res_last,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  output logic              tx_busy,
  output logic [15:0]       frames_sent
);

  localparam int unsigned FRAME_W = DATA_W + 2 * IDX_W + 8;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTF_W  = PTR_W + 1;
  localparam int unsigned MAX_CNT = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;
  localparam int unsigned RISE_W  = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RISE_W-1:0]   rises_q, rises_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;
  logic [15:0]         frames_q, frames_d;
  logic                busy_q, busy_d;

  logic [FRAME_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTF_W-1:0]   count_q, count_d;

  logic                push, pop, full, empty, cnt_done, gap_done;
  logic [FRAME_W-1:0]  push_frame, head;

  assign full       = (count_q == CNTF_W'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign res_ready  = !rst && !full;
  assign push       = res_valid && res_ready;
  assign push_frame = {res_val, res_row, res_col, 7'b0, res_last};
  assign head       = mem_q[rd_ptr_q];
  assign cnt_done   = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign gap_done   = (cnt_q == CNT_W'(CS_GAP - 1));

  assign spi_sclk    = sclk_q;
  assign spi_cs_n    = cs_n_q;
  assign spi_mosi    = mosi_q;
  assign tx_busy     = busy_q;
  assign frames_sent = frames_q;

  // FIFO storage write; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_frame;
  end

  // Frame sequencer: next state, shift/serial outputs and FIFO pointers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rises_d  = rises_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    mosi_d   = mosi_q;
    frames_d = frames_q;
    pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        cnt_d  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          cs_n_d  = 1'b0;
          mosi_d  = head[FRAME_W-1];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rises_d = RISE_W'(1);
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (rises_q == RISE_W'(FRAME_W)) begin
              state_d = S_HOLD;
            end else begin
              shreg_d = shreg_q << 1;
              mosi_d  = shreg_q[FRAME_W-2];
            end
          end else begin
            sclk_d  = 1'b1;
            rises_d = rises_q + RISE_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_done) begin
          cnt_d    = '0;
          cs_n_d   = 1'b1;
          mosi_d   = 1'b0;
          frames_d = frames_q + 16'd1;
          state_d  = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNTF_W'(push) - CNTF_W'(pop);
    busy_d   = (count_d != '0) || (state_d != S_IDLE);
  end

  // State and datapath registers; reset abandons any frame and empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rises_q  <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      frames_q <= '0;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rises_q  <= rises_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      frames_q <= frames_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_spi_result_tx.sv
// Self-checking bench for spi_result_tx: default-parameter instance with a
// frame-decoding monitor and scoreboard, plus a CLK_DIV=1/CS_GAP=1 instance.
module tb_spi_result_tx;

  localparam int unsigned D      = 10;
  localparam int unsigned GAP    = 4;
  localparam int unsigned DEPTH  = 4;

  typedef struct {
    logic [31:0] val;
    logic [15:0] row;
    logic [15:0] col;
    logic        last;
    logic [71:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        res_valid, res_ready, res_last;
  logic [31:0] res_val;
  logic [15:0] res_row, res_col;
  logic        spi_sclk, spi_cs_n, spi_mosi, tx_busy;
  logic [15:0] frames_sent;

  logic        res_valid1, res_ready1, res_last1;
  logic [31:0] res_val1;
  logic [15:0] res_row1, res_col1;
  logic        spi_sclk1, spi_cs_n1, spi_mosi1, tx_busy1;
  logic [15:0] frames_sent1;

  int n_checks = 0;
  int n_err    = 0;

  logic [71:0] exp_q[$];
  vec_t        vecs[13];

  spi_result_tx #(.CLK_DIV(D), .CS_GAP(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_val(res_val), .res_row(res_row), .res_col(res_col), .res_last(res_last),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .tx_busy(tx_busy), .frames_sent(frames_sent)
  );

  spi_result_tx #(.CLK_DIV(1), .CS_GAP(1)) dut1 (
    .clk(clk), .rst(rst),
    .res_valid(res_valid1), .res_ready(res_ready1),
    .res_val(res_val1), .res_row(res_row1), .res_col(res_col1), .res_last(res_last1),
    .spi_sclk(spi_sclk1), .spi_cs_n(spi_cs_n1), .spi_mosi(spi_mosi1),
    .tx_busy(tx_busy1), .frames_sent(frames_sent1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    n_checks++;
    if (act < min) begin
      n_err++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  // Monitor for the default instance: decodes frames and checks timing
  logic [71:0] mon_sh;
  int          mon_rises = 0, mon_low = 0, mon_high = 0, rx_count = 0;
  bit          mon_prev_sclk = 1'b0, mon_prev_csn = 1'b1, mon_seen = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_prev_sclk = 1'b0;
      mon_prev_csn  = 1'b1;
      mon_rises     = 0;
      mon_low       = 0;
      mon_high      = 0;
      mon_seen      = 1'b0;
    end else begin
      if (spi_cs_n == 1'b0) begin
        if (mon_prev_csn) begin
          if (mon_seen) check_ge("cs_gap", mon_high, int'(GAP) + 1);
          mon_rises = 0;
          mon_low   = 0;
          mon_sh    = '0;
        end
        mon_low++;
        if (spi_sclk && !mon_prev_sclk) begin
          mon_sh = {mon_sh[70:0], spi_mosi};
          mon_rises++;
        end
      end else begin
        if (!mon_prev_csn) begin
          check("rise_count", 72'(mon_rises), 72'd72);
          check("cs_low_cycles", 72'(mon_low), 72'(145 * D));
          check("busy_at_cs_rise", 72'(tx_busy), 72'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 72'd1, 72'd0);
          end else begin
            check("frame_data", mon_sh, exp_q.pop_front());
          end
          rx_count++;
          mon_seen = 1'b1;
          mon_high = 0;
        end
        mon_high++;
      end
      mon_prev_sclk = spi_sclk;
      mon_prev_csn  = spi_cs_n;
    end
  end

  // Drive one entry with valid held high until accepted; called at a negedge
  task automatic push_vec(input vec_t v, output int waited);
    waited    = 0;
    res_val   = v.val;
    res_row   = v.row;
    res_col   = v.col;
    res_last  = v.last;
    res_valid = 1'b1;
    while (!res_ready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (res_ready) exp_q.push_back(v.exp);
    else check("push_timeout", 72'd1, 72'd0);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 72'(tx_busy), 72'd0);
  endtask

  // Receive one frame from the CLK_DIV=1 instance
  task automatic rx1(output logic [71:0] fr, output int edges, output int low,
                     output int gap_hi, output bit per_ok, output bit to);
    int n = 0, cyc = 0, last_rise = -1;
    bit prev = 1'b0;
    fr = '0; edges = 0; low = 0; gap_hi = 0; per_ok = 1'b1; to = 1'b0;
    @(negedge clk);
    while (spi_cs_n1 && n < 500) begin
      gap_hi++;
      n++;
      @(negedge clk);
    end
    while (!spi_cs_n1 && n < 1500) begin
      low++;
      n++;
      if (spi_sclk1 && !prev) begin
        fr = {fr[70:0], spi_mosi1};
        edges++;
        if (last_rise >= 0 && (cyc - last_rise) != 2) per_ok = 1'b0;
        last_rise = cyc;
      end
      prev = spi_sclk1;
      cyc++;
      @(negedge clk);
    end
    if (n >= 500 && low == 0) to = 1'b1;
    if (!spi_cs_n1) to = 1'b1;
  endtask

  initial begin
    int waited, first_stall;
    logic [71:0] fr;
    int edges, low, gap_hi;
    bit per_ok, to;

    vecs[0] = '{32'hDEADBEEF, 16'd3, 16'd7, 1'b1, 72'hDEADBEEF_0003_0007_01};
    for (int i = 0; i < 8; i++) begin
      vecs[1 + i].val  = 32'(i);
      vecs[1 + i].row  = 16'(i + 1);
      vecs[1 + i].col  = 16'(i + 2);
      vecs[1 + i].last = (i == 7);
      vecs[1 + i].exp  = {32'(i), 16'(i + 1), 16'(i + 2), 7'b0, (i == 7) ? 1'b1 : 1'b0};
    end
    vecs[9]  = '{32'h12345678, 16'h00AA, 16'h0055, 1'b0, 72'h12345678_00AA_0055_00};
    vecs[10] = '{32'h11111111, 16'h1111, 16'h1111, 1'b0, 72'h11111111_1111_1111_00};
    vecs[11] = '{32'h22222222, 16'h2222, 16'h2222, 1'b1, 72'h22222222_2222_2222_01};
    vecs[12] = '{32'h33333333, 16'h3333, 16'h3333, 1'b0, 72'h33333333_3333_3333_00};

    res_valid = 1'b0; res_val = '0; res_row = '0; res_col = '0; res_last = 1'b0;
    res_valid1 = 1'b0; res_val1 = '0; res_row1 = '0; res_col1 = '0; res_last1 = 1'b0;
    rst = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    check("rst_cs_n", 72'(spi_cs_n), 72'd1);
    check("rst_sclk", 72'(spi_sclk), 72'd0);
    check("rst_mosi", 72'(spi_mosi), 72'd0);
    check("rst_ready", 72'(res_ready), 72'd0);
    check("rst_busy", 72'(tx_busy), 72'd0);
    check("rst_frames", 72'(frames_sent), 72'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 72'(res_ready), 72'd1);
    check("ready1_after_rst", 72'(res_ready1), 72'd1);
    @(negedge clk);

    // Single frame
    push_vec(vecs[0], waited);
    res_valid = 1'b0;
    wait_idle();
    check("frames_after_single", 72'(frames_sent), 72'd1);

    // Burst of 8 with valid held high; ready must drop with DEPTH entries pending
    first_stall = -1;
    for (int i = 0; i < 8; i++) begin
      push_vec(vecs[1 + i], waited);
      if (waited > 0 && first_stall < 0) first_stall = i;
    end
    res_valid = 1'b0;
    check("accepted_before_stall", 72'(first_stall), 72'(DEPTH + 1));
    wait_idle();
    check("frames_after_burst", 72'(frames_sent), 72'd9);
    check("burst_rx_count", 72'(rx_count), 72'd9);

    // Reset mid-frame with two entries queued behind the active one
    for (int i = 10; i < 13; i++) push_vec(vecs[i], waited);
    res_valid = 1'b0;
    for (int n = 0; n < 5000 && mon_rises < 30; n++) @(posedge clk);
    check_ge("reached_30_rises", mon_rises, 30);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_cs_n", 72'(spi_cs_n), 72'd1);
    check("midrst_sclk", 72'(spi_sclk), 72'd0);
    check("midrst_busy", 72'(tx_busy), 72'd0);
    check("midrst_frames", 72'(frames_sent), 72'd0);
    check("midrst_ready", 72'(res_ready), 72'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("flushed_busy", 72'(tx_busy), 72'd0);
    check("flushed_cs_n", 72'(spi_cs_n), 72'd1);
    check("rx_count_after_rst", 72'(rx_count), 72'd9);
    push_vec(vecs[9], waited);
    res_valid = 1'b0;
    wait_idle();
    check("frames_after_rst_frame", 72'(frames_sent), 72'd1);
    check("rx_count_total", 72'(rx_count), 72'd10);
    check("scoreboard_empty", 72'(exp_q.size()), 72'd0);

    // CLK_DIV=1, CS_GAP=1 instance: two frames back to back
    fork
      begin
        @(negedge clk);
        res_val1 = 32'h00000001; res_row1 = 16'hFFFF; res_col1 = 16'h0000; res_last1 = 1'b0;
        res_valid1 = 1'b1;
        @(negedge clk);
        res_val1 = 32'hA5A5A5A5; res_row1 = 16'h1234; res_col1 = 16'h8765; res_last1 = 1'b1;
        @(negedge clk);
        res_valid1 = 1'b0;
      end
      begin
        rx1(fr, edges, low, gap_hi, per_ok, to);
        check("d1_f0_timeout", 72'(to), 72'd0);
        check("d1_f0_data", fr, 72'h00000001_FFFF_0000_00);
        check("d1_f0_rises", 72'(edges), 72'd72);
        check("d1_f0_cs_low", 72'(low), 72'd145);
        check("d1_f0_period2", 72'(per_ok), 72'd1);
        check("d1_f0_frames", 72'(frames_sent1), 72'd1);
        rx1(fr, edges, low, gap_hi, per_ok, to);
        check("d1_f1_timeout", 72'(to), 72'd0);
        check("d1_gap", 72'(gap_hi + 1), 72'd2);
        check("d1_f1_data", fr, 72'hA5A5A5A5_1234_8765_01);
        check("d1_f1_rises", 72'(edges), 72'd72);
        check("d1_f1_cs_low", 72'(low), 72'd145);
        check("d1_f1_frames", 72'(frames_sent1), 72'd2);
      end
    join
    repeat (4) @(negedge clk);
    check("d1_idle", 72'(tx_busy1), 72'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
